// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : shared UART constants, FSM state type and divisor helper
// Rev 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int DEF_DIV = 434;
  localparam int MIN_DIV = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // Zero selects the default rate; anything below the minimum is clamped.
  function automatic logic [15:0] eff_div_f(input logic [15:0] cfg, input logic [15:0] def_div);
    if (cfg == 16'd0) return def_div;
    if (cfg < 16'(MIN_DIV)) return 16'(MIN_DIV);
    return cfg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_baud_gen : per-bit clock counter, pulses bit_end on the last clock
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_baud_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart_i,
  input  logic [15:0] eff_div_i,
  output logic        bit_end_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign bit_end_o = (cnt_q == (eff_div_i - 16'd1));

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (restart_i || bit_end_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_drain.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_drain : drains a show-ahead FIFO onto a UART line, frames back-to-back
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DEF_DIV   = uart_pkg::DEF_DIV,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          cfg_div_i,
  input  logic                 tx_en_i,
  input  logic [DATA_BITS-1:0] fifo_dout_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_deq_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);

  state_e               state_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_q;
  logic [IDX_W-1:0]     idx_q;
  logic [15:0]          eff_div_q;
  logic                 tx_q;
  logic                 busy_q;

  logic bit_end;
  logic last_stop;
  logic load;

  assign last_stop  = (state_q == ST_STOP) && bit_end && (idx_q == IDX_W'(STOP_BITS - 1));
  assign load       = !rst && tx_en_i && !fifo_empty_i && ((state_q == ST_IDLE) || last_stop);
  assign fifo_deq_o = load;
  assign tx_o       = tx_q;
  assign busy_o     = busy_q;

  uart_baud_gen u_baud (
    .clk       (clk),
    .rst       (rst),
    .restart_i (load || (state_q == ST_IDLE)),
    .eff_div_i (eff_div_q),
    .bit_end_o (bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      idx_q     <= '0;
      eff_div_q <= 16'(MIN_DIV);
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else if (load) begin
      state_q   <= ST_START;
      shreg_q   <= fifo_dout_i;
      par_q     <= (PARITY == PARITY_ODD) ? ~^fifo_dout_i : ^fifo_dout_i;
      idx_q     <= '0;
      eff_div_q <= eff_div_f(cfg_div_i, 16'(DEF_DIV));
      tx_q      <= 1'b0;
      busy_q    <= 1'b1;
    end else if (bit_end && (state_q != ST_IDLE)) begin
      // tx_q is loaded with the value of the bit that starts next cycle.
      case (state_q)
        ST_START: begin
          state_q <= ST_DATA;
          tx_q    <= shreg_q[0];
          shreg_q <= shreg_q >> 1;
          idx_q   <= '0;
        end
        ST_DATA: begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_q <= '0;
            if (PARITY != PARITY_NONE) begin
              state_q <= ST_PARITY;
              tx_q    <= par_q;
            end else begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end
          end else begin
            tx_q    <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
            idx_q   <= idx_q + IDX_W'(1);
          end
        end
        ST_PARITY: begin
          state_q <= ST_STOP;
          tx_q    <= 1'b1;
          idx_q   <= '0;
        end
        ST_STOP: begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
